macarray_seq: RTL and testbench

//  - Control sequencer for the 8x8 INT8 MAC array. One job computes O[TxM] = I[TxN] x W[NxM].
//  - Drives enables and addresses for the input, weight and output SRAMs. Issues load/valid/select

---
 rtl/macarray_seq_pkg.sv | 30 +++
 rtl/macarray_seq_if.sv | 40 ++++
 rtl/macarray_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_macarray_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/macarray_seq_pkg.sv
// Shared types and constants for the MAC-array control sequencer.
// Holds the FSM state encoding, MNT field layout and SRAM geometry.
package macarray_pkg;

    localparam int DIM       = 8;
    localparam int AW_IW     = 3;
    localparam int AW_O      = 4;
    localparam int MNT_W     = 12;
    localparam int FLD_W     = 4;
    localparam int MNT_M_LSB = 8;
    localparam int MNT_N_LSB = 4;
    localparam int MNT_T_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LDW,
        ST_RD,
        ST_WAIT,
        ST_WR_LO,
        ST_WR_HI,
        ST_ZERO,
        ST_FIN
    } state_t;

    // A job dimension is usable only when it lies in 1..DIM.
    function automatic logic fld_ok(input logic [FLD_W-1:0] f);
        return (f != '0) && (f <= FLD_W'(DIM));
    endfunction

endpackage

// File: rtl/macarray_seq_if.sv
// Job request / SRAM-control bundle between the top level, the sequencer and the datapath.
// The sequencer uses the slave view; whoever issues jobs and watches strobes uses master.
interface macarray_seq_if;
    import macarray_pkg::*;

    logic               start;
    logic [MNT_W-1:0]   mnt;
    logic               busy;
    logic               done;
    logic               err;
    logic [FLD_W-1:0]   cfg_m;
    logic [FLD_W-1:0]   cfg_n;
    logic               en_w;
    logic [AW_IW-1:0]   addr_w;
    logic               en_i;
    logic [AW_IW-1:0]   addr_i;
    logic               wld;
    logic [AW_IW-1:0]   wld_idx;
    logic               ivld;
    logic               en_o;
    logic               rw_o;
    logic [AW_O-1:0]    addr_o;
    logic               osel;
    logic               ozero;

    modport slave (
        input  start, mnt,
        output busy, done, err, cfg_m, cfg_n,
               en_w, addr_w, en_i, addr_i, wld, wld_idx, ivld,
               en_o, rw_o, addr_o, osel, ozero
    );

    modport master (
        output start, mnt,
        input  busy, done, err, cfg_m, cfg_n,
               en_w, addr_w, en_i, addr_i, wld, wld_idx, ivld,
               en_o, rw_o, addr_o, osel, ozero
    );

endinterface

// File: rtl/macarray_seq.sv
// Control sequencer for the 8x8 INT8 MAC array: loads weights, streams input rows,
// writes result halves and zero-fills the unused tail of the output SRAM.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a START rising edge
// LDW     | weight SRAM read j = 0..M-1 (WLD for row j follows one cycle later)
// RD      | input SRAM read for row t
// WAIT    | DP_LAT cycles of datapath latency, IVLD in the first one
// WR_LO   | write columns 0-3 of row t to ADDR_O = 2t
// WR_HI   | write columns 4-7 of row t to ADDR_O = 2t+1
// ZERO    | write zeros to ADDR_O = 2T..15
// FIN     | one-cycle DONE pulse, BUSY already low
module macarray_seq
    import macarray_pkg::*;
#(
    parameter int DP_LAT = 1
)
(
    input  logic           i_clk,
    input  logic           i_rst_n,
    macarray_seq_if.slave  bus
);

    localparam logic [1:0] WAIT_INIT = 2'(DP_LAT - 1);

    state_t             r_state;
    logic               r_start_q;
    logic [FLD_W-1:0]   r_m;
    logic [FLD_W-1:0]   r_n;
    logic [FLD_W-1:0]   r_tc;
    logic [3:0]         r_j;
    logic [3:0]         r_t;
    logic [1:0]         r_wait;
    logic [3:0]         r_za;

    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               r_en_w;
    logic [AW_IW-1:0]   r_addr_w;
    logic               r_en_i;
    logic [AW_IW-1:0]   r_addr_i;
    logic               r_wld;
    logic [AW_IW-1:0]   r_wld_idx;
    logic               r_ivld;
    logic               r_en_o;
    logic               r_rw_o;
    logic [AW_O-1:0]    r_addr_o;
    logic               r_osel;
    logic               r_ozero;

    logic [FLD_W-1:0]   w_m;
    logic [FLD_W-1:0]   w_n;
    logic [FLD_W-1:0]   w_t;
    logic               w_cfg_ok;
    logic               w_accept;
    logic [3:0]         w_j_nxt;
    logic [3:0]         w_t_nxt;
    logic [3:0]         w_za_nxt;

    assign w_m      = bus.mnt[MNT_M_LSB +: FLD_W];
    assign w_n      = bus.mnt[MNT_N_LSB +: FLD_W];
    assign w_t      = bus.mnt[MNT_T_LSB +: FLD_W];
    assign w_cfg_ok = fld_ok(w_m) && fld_ok(w_n) && fld_ok(w_t);
    assign w_accept = bus.start && !r_start_q && (r_state == ST_IDLE);
    assign w_j_nxt  = r_j + 4'd1;
    assign w_t_nxt  = r_t + 4'd1;
    assign w_za_nxt = r_za + 4'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_start_q <= 1'b0;
            r_m       <= '0;
            r_n       <= '0;
            r_tc      <= '0;
            r_j       <= '0;
            r_t       <= '0;
            r_wait    <= '0;
            r_za      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_en_w    <= 1'b0;
            r_addr_w  <= '0;
            r_en_i    <= 1'b0;
            r_addr_i  <= '0;
            r_wld     <= 1'b0;
            r_wld_idx <= '0;
            r_ivld    <= 1'b0;
            r_en_o    <= 1'b0;
            r_rw_o    <= 1'b0;
            r_addr_o  <= '0;
            r_osel    <= 1'b0;
            r_ozero   <= 1'b0;
        end else begin
            r_start_q <= bus.start;

            // Strobes and addresses describe the state being entered; idle by default.
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_en_w    <= 1'b0;
            r_addr_w  <= '0;
            r_en_i    <= 1'b0;
            r_addr_i  <= '0;
            r_wld     <= 1'b0;
            r_wld_idx <= '0;
            r_ivld    <= 1'b0;
            r_en_o    <= 1'b0;
            r_rw_o    <= 1'b0;
            r_addr_o  <= '0;
            r_osel    <= 1'b0;
            r_ozero   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (!w_cfg_ok) begin
                            r_err <= 1'b1;
                        end else begin
                            r_m     <= w_m;
                            r_n     <= w_n;
                            r_tc    <= w_t;
                            r_j     <= '0;
                            r_busy  <= 1'b1;
                            r_en_w  <= 1'b1;
                            r_state <= ST_LDW;
                        end
                    end
                end

                ST_LDW: begin
                    r_wld     <= 1'b1;
                    r_wld_idx <= r_j[AW_IW-1:0];
                    if (r_j == r_m - 4'd1) begin
                        r_t     <= '0;
                        r_en_i  <= 1'b1;
                        r_state <= ST_RD;
                    end else begin
                        r_j      <= w_j_nxt;
                        r_en_w   <= 1'b1;
                        r_addr_w <= w_j_nxt[AW_IW-1:0];
                    end
                end

                ST_RD: begin
                    r_ivld  <= 1'b1;
                    r_wait  <= WAIT_INIT;
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (r_wait == 2'd0) begin
                        r_en_o   <= 1'b1;
                        r_rw_o   <= 1'b1;
                        r_addr_o <= {r_t[AW_O-2:0], 1'b0};
                        r_state  <= ST_WR_LO;
                    end else begin
                        r_wait <= r_wait - 2'd1;
                    end
                end

                ST_WR_LO: begin
                    r_en_o   <= 1'b1;
                    r_rw_o   <= 1'b1;
                    r_addr_o <= {r_t[AW_O-2:0], 1'b1};
                    r_osel   <= 1'b1;
                    r_state  <= ST_WR_HI;
                end

                ST_WR_HI: begin
                    if (r_t == r_tc - 4'd1) begin
                        if (r_tc == FLD_W'(DIM)) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            r_za     <= {r_tc[AW_O-2:0], 1'b0};
                            r_en_o   <= 1'b1;
                            r_rw_o   <= 1'b1;
                            r_ozero  <= 1'b1;
                            r_addr_o <= {r_tc[AW_O-2:0], 1'b0};
                            r_state  <= ST_ZERO;
                        end
                    end else begin
                        r_t      <= w_t_nxt;
                        r_en_i   <= 1'b1;
                        r_addr_i <= w_t_nxt[AW_IW-1:0];
                        r_state  <= ST_RD;
                    end
                end

                ST_ZERO: begin
                    // Tail counter terminates at the last output word rather than wrapping.
                    if (r_za == 4'hF) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end else begin
                        r_za     <= w_za_nxt;
                        r_en_o   <= 1'b1;
                        r_rw_o   <= 1'b1;
                        r_ozero  <= 1'b1;
                        r_addr_o <= w_za_nxt;
                    end
                end

                ST_FIN: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.cfg_m   = r_m;
    assign bus.cfg_n   = r_n;
    assign bus.en_w    = r_en_w;
    assign bus.addr_w  = r_addr_w;
    assign bus.en_i    = r_en_i;
    assign bus.addr_i  = r_addr_i;
    assign bus.wld     = r_wld;
    assign bus.wld_idx = r_wld_idx;
    assign bus.ivld    = r_ivld;
    assign bus.en_o    = r_en_o;
    assign bus.rw_o    = r_rw_o;
    assign bus.addr_o  = r_addr_o;
    assign bus.osel    = r_osel;
    assign bus.ozero   = r_ozero;

endmodule

// File: tb/tb_macarray_seq.sv
// Directed bench for macarray_seq: per-cycle strobe traces against a closed-form timeline,
// plus the hand-derived DONE cycles, config rejects, START filtering, abort and DP_LAT=3.
module tb_macarray_seq;
    import macarray_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    macarray_seq_if u_if ();
    macarray_seq_if u_if3 ();

    assign u_if3.start = u_if.start;
    assign u_if3.mnt   = u_if.mnt;

    macarray_seq #(.DP_LAT(1)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (u_if.slave)
    );

    macarray_seq #(.DP_LAT(3)) u_dut3 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (u_if3.slave)
    );

    // {busy,done,err,en_w,addr_w,en_i,addr_i,wld,wld_idx,ivld,en_o,rw_o,addr_o,osel,ozero}
    logic [23:0] v0, v1;
    assign v0 = {u_if.busy, u_if.done, u_if.err,
                 u_if.en_w, (u_if.en_w ? u_if.addr_w : 3'd0),
                 u_if.en_i, (u_if.en_i ? u_if.addr_i : 3'd0),
                 u_if.wld,  (u_if.wld ? u_if.wld_idx : 3'd0),
                 u_if.ivld, u_if.en_o, u_if.rw_o,
                 (u_if.en_o ? u_if.addr_o : 4'd0), (u_if.en_o ? u_if.osel : 1'b0), u_if.ozero};
    assign v1 = {u_if3.busy, u_if3.done, u_if3.err,
                 u_if3.en_w, (u_if3.en_w ? u_if3.addr_w : 3'd0),
                 u_if3.en_i, (u_if3.en_i ? u_if3.addr_i : 3'd0),
                 u_if3.wld,  (u_if3.wld ? u_if3.wld_idx : 3'd0),
                 u_if3.ivld, u_if3.en_o, u_if3.rw_o,
                 (u_if3.en_o ? u_if3.addr_o : 4'd0), (u_if3.en_o ? u_if3.osel : 1'b0), u_if3.ozero};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Expected strobes in cycle c after accept (cycle 0), derived from the job timeline.
    function automatic logic [23:0] exp_vec(input int c, input int m, input int t, input int l);
        logic busy, done, en_w, en_i, wld, ivld, en_o, osel, ozero;
        logic [2:0] aw, ai, wi;
        logic [3:0] ao;
        int rd0, p, z0, dn, k, tt, ph;
        rd0 = m + 1;
        p   = 3 + l;
        z0  = rd0 + t * p;
        dn  = z0 + 16 - 2 * t;
        busy = (c >= 1) && (c < dn);
        done = (c == dn);
        en_w = (c >= 1) && (c <= m);
        aw   = en_w ? 3'(c - 1) : 3'd0;
        wld  = (c >= 2) && (c <= m + 1);
        wi   = wld ? 3'(c - 2) : 3'd0;
        en_i = 1'b0; ai = 3'd0; ivld = 1'b0; en_o = 1'b0; ao = 4'd0; osel = 1'b0; ozero = 1'b0;
        if (c >= rd0 && c < z0) begin
            k  = c - rd0;
            tt = k / p;
            ph = k % p;
            if (ph == 0) begin en_i = 1'b1; ai = 3'(tt); end
            ivld = (ph == 1);
            if (ph == p - 2) begin en_o = 1'b1; ao = 4'(2 * tt); end
            if (ph == p - 1) begin en_o = 1'b1; ao = 4'(2 * tt + 1); osel = 1'b1; end
        end
        if (c >= z0 && c < dn) begin
            en_o = 1'b1; ozero = 1'b1; ao = 4'(2 * t + c - z0);
        end
        return {busy, done, 1'b0, en_w, aw, en_i, ai, wld, wi, ivld, en_o, en_o, ao, osel, ozero};
    endfunction

    task automatic run_job(input logic [11:0] mnt, input int sel, input int lat, input bit toggle,
                           input int abort_c, input int done_hand, input string tag);
        int m, n, t, dn, last, done_obs, ivld_c, wrlo_c;
        bit legal;
        logic [23:0] obs, exp;
        m = int'(mnt[11:8]);
        n = int'(mnt[7:4]);
        t = int'(mnt[3:0]);
        legal = (m >= 1) && (m <= 8) && (n >= 1) && (n <= 8) && (t >= 1) && (t <= 8);
        dn = (m + 1) + t * (3 + lat) + 16 - 2 * t;
        last = legal ? dn + 1 : 4;
        done_obs = 0; ivld_c = 0; wrlo_c = 0;
        @(negedge clk);
        u_if.mnt   = mnt;
        u_if.start = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            u_if.start = toggle && (c >= 2) && (c < dn - 2) && (c % 3 == 0);
            obs = (sel != 0) ? v1 : v0;
            exp = legal ? exp_vec(c, m, t, lat) : ((c == 1) ? 24'h200000 : 24'h000000);
            chk($sformatf("%s c%0d", tag, c), 32'(obs), 32'(exp));
            if (obs[22] && done_obs == 0) done_obs = c;
            if (obs[8] && ivld_c == 0) ivld_c = c;
            if (obs[7] && !obs[0] && wrlo_c == 0) wrlo_c = c;
            if (legal && c == 1) begin
                chk({tag, " cfg_m"}, 32'((sel != 0) ? u_if3.cfg_m : u_if.cfg_m), 32'(mnt[11:8]));
                chk({tag, " cfg_n"}, 32'((sel != 0) ? u_if3.cfg_n : u_if.cfg_n), 32'(mnt[7:4]));
            end
            if (c == abort_c) begin
                rst_n = 1'b0;
                #1;
                chk({tag, " rst outs"}, 32'(v0), 32'd0);
                chk({tag, " rst cfg"}, 32'({u_if.cfg_m, u_if.cfg_n}), 32'd0);
                @(negedge clk);
                chk({tag, " rst hold"}, 32'(v0), 32'd0);
                rst_n = 1'b1;
                break;
            end
        end
        if (legal && abort_c == 0) begin
            chk({tag, " done cyc"}, 32'(done_obs), 32'((done_hand > 0) ? done_hand : dn));
            chk({tag, " ivld->wrlo"}, 32'(wrlo_c - ivld_c), 32'(lat));
        end
    endtask

    initial begin
        u_if.start = 1'b0;
        u_if.mnt   = 12'h000;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outs", 32'(v0), 32'd0);
        chk("reset outs lat3", 32'(v1), 32'd0);
        chk("reset cfg", 32'({u_if.cfg_m, u_if.cfg_n}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(12'h888, 0, 1, 1'b0, 0, 41, "888");
        run_job(12'h777, 0, 1, 1'b0, 0, 38, "777");
        run_job(12'h111, 0, 1, 1'b0, 0, 20, "111");
        run_job(12'h077, 0, 1, 1'b0, 0, 0,  "err077");
        run_job(12'h897, 0, 1, 1'b0, 0, 0,  "err897");
        run_job(12'h353, 0, 1, 1'b1, 0, 0,  "toggle");
        run_job(12'h888, 0, 1, 1'b0, 22, 0, "abort");
        run_job(12'h444, 0, 1, 1'b0, 0, 0,  "post");
        repeat (40) @(negedge clk);
        run_job(12'h222, 1, 3, 1'b0, 0, 27, "lat3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
